// File: rtl/booth_mac_acc.sv
// booth_mac_acc: packet multiply-accumulate back end for booth_mult products.
// Build option BOOTH_MAC_SAT_EN clamps the accumulator on signed overflow instead of wrapping.

// Sign-extending add of one product into the accumulator, with overflow detect.
module booth_mac_add #(
    parameter int PW = 32,
    parameter int AW = 40
) (
    input  logic [AW-1:0] a,
    input  logic [PW-1:0] p,
    output logic [AW-1:0] sum,
    output logic          ovf
);
    logic [AW-1:0] b;
    logic [AW-1:0] raw;

    always_comb begin
        b   = AW'($signed(p));
        raw = a + b;
        // Same-sign addends whose result flips sign overflowed.
        ovf = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);
`ifdef BOOTH_MAC_SAT_EN
        if (ovf)
            sum = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            sum = raw;
`else
        sum = raw;
`endif
    end
endmodule

module booth_mac_acc #(
    parameter int PW = 32,
    parameter int AW = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_valid,
    output logic          p_ready,
    input  logic [PW-1:0] p,
    input  logic          p_last,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [AW-1:0] acc,
    output logic [15:0]   acc_cnt,
    output logic          acc_ovf
);
    typedef enum logic {S_ACC, S_DONE} state_t;

    state_t        state;
    logic [AW-1:0] add_sum;
    logic          add_ovf;

    booth_mac_add #(.PW(PW), .AW(AW)) u_add (
        .a   (acc),
        .p   (p),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // No path from p_valid: ready depends only on state and reset.
    assign p_ready = (state == S_ACC) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_ACC;
            acc       <= '0;
            acc_cnt   <= '0;
            acc_ovf   <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (p_valid) begin
                        acc <= add_sum;
                        if (acc_cnt != 16'hFFFF)
                            acc_cnt <= acc_cnt + 16'd1;
                        if (add_ovf)
                            acc_ovf <= 1'b1;
                        if (p_last) begin
                            state     <= S_DONE;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Result holds until taken; clearing here makes the next packet start from 0.
                    if (acc_ready) begin
                        state     <= S_ACC;
                        acc_valid <= 1'b0;
                        acc       <= '0;
                        acc_cnt   <= '0;
                        acc_ovf   <= 1'b0;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mac_acc.sv
// Self-checking bench for booth_mac_acc: directed spec cases plus randomized packets vs an arithmetic model.
`timescale 1ns/1ps
module tb_booth_mac_acc;
    localparam int PW  = 32;
    localparam int AW  = 40;
    localparam int AWB = 34;
`ifdef BOOTH_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           a_pv = 0, a_pl = 0, a_ar = 0;
    logic [PW-1:0]  a_p = '0;
    logic           a_prdy, a_av, a_ovf;
    logic [AW-1:0]  a_acc;
    logic [15:0]    a_cnt;

    logic           b_pv = 0, b_pl = 0, b_ar = 0;
    logic [PW-1:0]  b_p = '0;
    logic           b_prdy, b_av, b_ovf;
    logic [AWB-1:0] b_acc;
    logic [15:0]    b_cnt;

    booth_mac_acc #(.PW(PW), .AW(AW)) dut_a (
        .clk(clk), .rst(rst), .p_valid(a_pv), .p_ready(a_prdy), .p(a_p), .p_last(a_pl),
        .acc_valid(a_av), .acc_ready(a_ar), .acc(a_acc), .acc_cnt(a_cnt), .acc_ovf(a_ovf)
    );

    booth_mac_acc #(.PW(PW), .AW(AWB)) dut_b (
        .clk(clk), .rst(rst), .p_valid(b_pv), .p_ready(b_prdy), .p(b_p), .p_last(b_pl),
        .acc_valid(b_av), .acc_ready(b_ar), .acc(b_acc), .acc_cnt(b_cnt), .acc_ovf(b_ovf)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state for dut_a: exact integer sum, clamped or wrapped into AW bits.
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input int aw, input longint v);
        longint t, hi, lo, span;
        span = longint'(1) <<< aw;
        hi   = (longint'(1) <<< (aw - 1)) - 1;
        lo   = -(longint'(1) <<< (aw - 1));
        t    = m_acc + v;
        if (t > hi || t < lo) begin
            m_ovf = 1'b1;
            if (SAT) t = (t > hi) ? hi : lo;
            else     t = (t > hi) ? t - span : t + span;
        end
        m_acc = t;
        if (m_cnt < 65535) m_cnt++;
    endtask

    task automatic a_state_chk(input string tag);
        chk({tag, "_acc"}, 64'($signed(a_acc)), m_acc);
        chk({tag, "_cnt"}, 64'(a_cnt), 64'(m_cnt));
        chk({tag, "_ovf"}, 64'(a_ovf), 64'(m_ovf));
    endtask

    task automatic a_beat(input logic [31:0] v, input bit last);
        a_pv = 1'b1; a_p = v; a_pl = last;
        chk("beat_p_ready", 64'(a_prdy), 64'd1);
        chk("beat_pre_valid", 64'(a_av), 64'd0);
        @(posedge clk); #1;
        a_pv = 1'b0; a_pl = 1'b0;
        model_beat(AW, longint'($signed(v)));
        a_state_chk("beat");
    endtask

    task automatic a_idle();
        a_pv = 1'b0; a_p = $urandom; a_pl = $urandom_range(0, 1);
        @(posedge clk); #1;
        a_pl = 1'b0;
        a_state_chk("idle");
    endtask

    task automatic a_result(input string tag);
        chk({tag, "_valid"}, 64'(a_av), 64'd1);
        chk({tag, "_p_ready"}, 64'(a_prdy), 64'd0);
        a_state_chk(tag);
    endtask

    task automatic a_take(input string tag);
        a_ar = 1'b1;
        @(posedge clk); #1;
        a_ar = 1'b0;
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        chk({tag, "_valid"}, 64'(a_av), 64'd0);
        chk({tag, "_p_ready"}, 64'(a_prdy), 64'd1);
        a_state_chk(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #2;
        chk("rst_p_ready", 64'(a_prdy), 64'd0);
        chk("rst_valid", 64'(a_av), 64'd0);
        a_state_chk("rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_p_ready", 64'(a_prdy), 64'd1);

        // Three-beat packet with acc_ready already high
        a_ar = 1'b1;
        a_beat(-32'sd50, 1'b0);
        a_beat(-32'sd5684, 1'b0);
        a_beat(-32'sd500, 1'b1);
        a_result("t1");
        chk("t1_acc_const", 64'(a_acc), 64'h00FF_FFFF_E7A6);
        a_take("t1_take");

        // Mixed-sign pair
        a_beat(32'h3FFF0001, 1'b0);
        a_beat(32'hC0008000, 1'b1);
        a_result("t2");
        chk("t2_acc_const", 64'(a_acc), 64'h00FF_FFFF_8001);
        a_take("t2_take");

        // Single-beat packet
        a_beat(-32'sd50, 1'b1);
        a_result("t3");
        a_take("t3_take");

        // Backpressure: result holds, beats refused
        a_beat($urandom, 1'b0);
        a_beat($urandom, 1'b1);
        a_pv = 1'b1; a_p = $urandom; a_pl = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            a_result("bp_hold");
        end
        a_pv = 1'b0; a_pl = 1'b0;
        a_take("bp_take");

        // Reset mid-packet
        a_beat(32'd7, 1'b0);
        a_beat(32'd9, 1'b0);
        rst = 1'b1; #1;
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        chk("mid_rst_p_ready", 64'(a_prdy), 64'd0);
        chk("mid_rst_valid", 64'(a_av), 64'd0);
        a_state_chk("mid_rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        a_beat(32'd25, 1'b1);
        a_result("post_rst");
        a_take("post_rst_take");

        // Randomized packets with idle gaps
        for (int k = 0; k < 25; k++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) a_idle();
                a_beat($urandom, j == n - 1);
            end
            a_result("rnd");
            a_take("rnd_take");
        end

        // Positive then negative overflow on the 40-bit accumulator
        for (int j = 0; j < 300; j++) a_beat(32'h7FFFFFFF, j == 299);
        a_result("ovf_pos");
        chk("ovf_pos_flag", 64'(a_ovf), 64'd1);
        a_take("ovf_pos_take");
        for (int j = 0; j < 300; j++) a_beat(32'h80000000, j == 299);
        a_result("ovf_neg");
        chk("ovf_neg_flag", 64'(a_ovf), 64'd1);
        a_take("ovf_neg_take");

        // 34-bit instance: nine beats of 0x3FFF0001
        for (int j = 0; j < 9; j++) begin
            b_pv = 1'b1; b_p = 32'h3FFF0001; b_pl = (j == 8);
            @(posedge clk); #1;
            b_pv = 1'b0; b_pl = 1'b0;
            if (j == 7) begin
                chk("b_ovf_after8", 64'(b_ovf), 64'd0);
                chk("b_acc_after8", 64'(b_acc), 64'h1_FFF8_0008);
            end
        end
        chk("b_valid", 64'(b_av), 64'd1);
        chk("b_cnt", 64'(b_cnt), 64'd9);
        chk("b_ovf", 64'(b_ovf), 64'd1);
        chk("b_acc", 64'(b_acc), SAT ? 64'h1_FFFF_FFFF : 64'h2_3FF7_0009);
        b_ar = 1'b1;
        @(posedge clk); #1;
        b_ar = 1'b0;
        chk("b_take_valid", 64'(b_av), 64'd0);
        chk("b_take_p_ready", 64'(b_prdy), 64'd1);

        // Count saturation: 65537 beats report 16'hFFFF
        for (int j = 0; j < 65537; j++) a_beat(32'd1, j == 65536);
        a_result("cnt_sat");
        chk("cnt_sat_const", 64'(a_cnt), 64'hFFFF);
        a_take("cnt_sat_take");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_mac_acc.md
# booth_mac_acc

Sequential multiply-accumulate back end that sits directly downstream of the combinational 16x16 signed `booth_mult` array. It takes the 32-bit signed product `p` as a stream of beats under a valid/ready handshake and sums each packet of products into a wide signed accumulator. On the beat marked last, it holds the packet total, beat count and overflow flag until the consumer takes them. It is the block that turns the multiplier into a dot-product engine.

## Interface
- `PW`, 32: product width; must match `booth_mult` output `p`.
- `AW`, 40: accumulator width; must be at least `PW`.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `p_valid` in 1: product beat present.
- `p_ready` out 1: block accepts a beat this cycle.
- `p` in PW: signed product, two's complement, from `booth_mult.p`.
- `p_last` in 1: qualifies the accepted beat as the final beat of the packet.
- `acc_valid` out 1: packet result held on `acc`, `acc_cnt`, `acc_ovf`.
- `acc_ready` in 1: consumer takes the result.
- `acc` out AW: signed packet sum.
- `acc_cnt` out 16: number of beats accepted in the packet.
- `acc_ovf` out 1: sticky flag; at least one signed overflow occurred during the packet.

## Operation
- The block has two states.
  - ACC: `p_ready=1`, `acc_valid=0`.
  - DONE: `p_ready=0`, `acc_valid=1`.
- A beat is accepted when `p_valid && p_ready` is high at the rising edge. On acceptance:
  - `acc <= acc + sext(p)`, computed AW bits wide.
  - `acc_cnt <= acc_cnt + 1`. The count saturates at 16'hFFFF and does not wrap.
- If the accepted beat also has `p_last=1`, the state moves ACC→DONE.
- In DONE, `acc_ready=1` at the edge clears `acc`, `acc_cnt` and `acc_ovf` to 0 and returns the state to ACC.
- In DONE with `acc_ready=0`, all outputs hold stable. `p_valid` is ignored.
- Beats are never accepted in DONE. There is no same-cycle result take and new beat, so each packet boundary costs one bubble cycle.
- Overflow is detected when both addends have the same sign and the AW-bit result has the other sign. Detection sets `acc_ovf` (sticky).
- The first beat of every packet adds to an accumulator value of 0.
- While `p_valid=0` in ACC, no state changes.

## Timing
- Reset, asynchronous on `rst` high:
  - `acc=0`, `acc_cnt=0`, `acc_ovf=0`, state ACC.
  - `acc_valid=0`.
  - `p_ready` is forced to 0 while `rst` is high, then 1 on the first cycle after release.
- Latency: for a last beat accepted at edge N, `acc_valid` is high and the final `acc` is valid in the cycle following edge N.
- Throughput is one beat per cycle within a packet. The minimum packet period is beats + 1 cycles.
- `p_ready` is a pure function of state and `rst`, with no combinational path from `p_valid`. `acc_valid` is registered.
- A `rst` assertion mid-packet discards the partial sum and count. No result is emitted.
- A `p_last` beat with `acc_cnt` already at 16'hFFFF reports `acc_cnt=16'hFFFF`.

## Configuration
- `BOOTH_MAC_SAT_EN` defined:
  - On overflow, `acc` clamps to 2^(AW-1)-1 for positive overflow, or -2^(AW-1) for negative overflow.
  - Later beats add to the clamped value.
  - `acc_ovf` is set.
- `BOOTH_MAC_SAT_EN` undefined:
  - `acc` wraps modulo 2^AW.
  - `acc_ovf` is still set.

## Test plan
- Packet of -50, -5684, -500 (last on the third beat), `acc_ready=1` → one cycle later `acc_valid=1`, `acc=40'hFFFFFFE7A6` (-6234), `acc_cnt=3`, `acc_ovf=0`. The next cycle has `p_ready=1`, `acc=0`.
- Packet of 32'h3FFF0001 then 32'hC0008000 (last) → `acc=40'hFFFFFF8001` (-32767), `acc_cnt=2`.
- Single beat -50 with `p_last=1` → `acc=-50`, `acc_cnt=1`, `acc_valid` high exactly one cycle after acceptance.
- Instance with `AW=34`, nine beats of 32'h3FFF0001 with last on beat 9:
  - With `BOOTH_MAC_SAT_EN` → `acc=34'h1FFFFFFFF`, `acc_ovf=1`.
  - Without it → `acc=34'h23FF70009`, `acc_ovf=1`.
  - In both cases the first 8 beats leave `acc_ovf=0`.
- Backpressure: result held with `acc_ready=0` for 5 cycles while `p_valid=1` → `p_ready=0` and `acc`, `acc_cnt`, `acc_ovf` stable throughout. When `acc_ready` goes to 1 → next cycle `acc_valid=0`, `p_ready=1`.
- Assert `rst` after 2 of 3 beats → `acc=0` and `acc_cnt=0` immediately. After release, a new 1-beat packet of 25 yields `acc=25`, `acc_cnt=1`.
